data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 167 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory with one outstanding request and a fixed access latency.
// Optional build macro DMEM_MISALIGN_CHECK_EN: flag accesses whose address is not a multiple of their size.
//
//   state  | meaning
//   S_IDLE | req_ready high, waiting for a request
//   S_BUSY | request latched, latency counter running down to zero
//   S_RESP | access done, response held until rsp_ready
module data_mem_responder #(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_accept, w_do_access;

  logic            r_write;
  logic [AW-1:0]   r_addr;
  logic [63:0]     r_wdata;
  logic [2:0]      r_funct3;

  logic [63:0]     r_rsp_rdata;
  logic            r_rsp_err;

  logic [7:0]      r_mem [DEPTH_BYTES];

  logic [2:0]      w_size_mask;
  logic [AW-1:0]   w_idx [8];
  logic [7:0]      w_lane_en;
  logic [63:0]     w_raw, w_load, w_rdata;
  logic            w_sign, w_misalign, w_err;
  logic            w_unused_addr;

  // Only the low AW address bits select storage; the rest alias.
  assign w_unused_addr = ^req_addr[63:AW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_do_access = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_do_access = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_addr   <= req_addr[AW-1:0];
      r_wdata  <= req_wdata;
      r_funct3 <= req_funct3;
    end
  end

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_size_mask = 3'd0;
      2'b01:   w_size_mask = 3'd1;
      2'b10:   w_size_mask = 3'd3;
      default: w_size_mask = 3'd7;
    endcase

    w_raw = '0;
    for (int i = 0; i < 8; i++) begin
      w_idx[i]     = r_addr + AW'(i);
      w_lane_en[i] = (3'(i) <= w_size_mask);
      if (w_lane_en[i]) w_raw[8*i +: 8] = r_mem[w_idx[i]];
    end

    w_sign = ~r_funct3[2];
    case (r_funct3[1:0])
      2'b00:   w_load = {{56{w_sign & w_raw[7]}},  w_raw[7:0]};
      2'b01:   w_load = {{48{w_sign & w_raw[15]}}, w_raw[15:0]};
      2'b10:   w_load = {{32{w_sign & w_raw[31]}}, w_raw[31:0]};
      default: w_load = w_raw;
    endcase

`ifdef DMEM_MISALIGN_CHECK_EN
    w_misalign = |(r_addr[2:0] & w_size_mask);
`else
    w_misalign = 1'b0;
`endif

    // funct3[2] on a store has no unsigned meaning, so it is rejected.
    w_err   = (r_write & r_funct3[2]) | w_misalign;
    w_rdata = (r_write | w_err) ? 64'd0 : w_load;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_do_access) begin
      r_rsp_rdata <= w_rdata;
      r_rsp_err   <= w_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DEPTH_BYTES; j++) r_mem[j] <= 8'h00;
    end else if (w_do_access && r_write && !w_err) begin
      for (int i = 0; i < 8; i++) begin
        if (w_lane_en[i]) r_mem[w_idx[i]] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: loads/stores, extension, wrap, backpressure, errors and reset.
module tb_data_mem_responder;

  localparam int LAT = 2;
  localparam logic [2:0] F_LB = 3'b000, F_LH = 3'b001, F_LW = 3'b010, F_LD = 3'b011;
  localparam logic [2:0] F_LBU = 3'b100, F_LHU = 3'b101, F_LWU = 3'b110;
  localparam logic [63:0] DW = 64'h1122_3344_5566_7788;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  int vectors = 0;
  int miscompares = 0;
  logic mis;

  data_mem_responder #(.DEPTH_BYTES(256), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Starts and ends at posedge+1 with the DUT idle.
  task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [2:0] f,
                      output logic [63:0] rd, output logic er, output int lat);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] rd; logic er; int lat;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    vectors++; if (rsp_rdata !== 64'd0) begin miscompares++; $display("FAIL rst_rsp_rdata got %h exp 0", rsp_rdata); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_err got %b exp 0", rsp_err); end
    xact(1'b0, 64'h80, 64'd0, F_LD, rd, er, lat);
    vectors++; if (rd !== 64'd0) begin miscompares++; $display("FAIL rst_mem_clear got %h exp 0", rd); end
  endtask

  task automatic test_dword();
    logic [63:0] rd; logic er; int lat;
    xact(1'b1, 64'h10, DW, F_LD, rd, er, lat);
    vectors++; if (rd !== 64'd0) begin miscompares++; $display("FAIL sd_rdata got %h exp 0", rd); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL sd_err got %b exp 0", er); end
    vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL sd_latency got %0d exp %0d", lat, LAT); end
    xact(1'b0, 64'h10, 64'd0, F_LD, rd, er, lat);
    vectors++; if (rd !== DW) begin miscompares++; $display("FAIL ld_rdata got %h exp %h", rd, DW); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL ld_err got %b exp 0", er); end
    vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL ld_latency got %0d exp %0d", lat, LAT); end
    xact(1'b0, 64'h0000_0001_0000_0010, 64'd0, F_LD, rd, er, lat);
    vectors++; if (rd !== DW) begin miscompares++; $display("FAIL ld_alias got %h exp %h", rd, DW); end
  endtask

  task automatic test_sign_ext();
    logic [63:0] rd; logic er; int lat;
    logic [63:0] t_addr [9] = '{64'h20, 64'h20, 64'h20, 64'h22, 64'h22, 64'h20, 64'h20, 64'h20, 64'h21};
    logic [2:0]  t_f3   [9] = '{F_LB, F_LBU, F_LHU, F_LH, F_LHU, F_LW, F_LWU, F_LD, F_LB};
    logic [63:0] t_exp  [9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_00FF,
                                64'hFFFF_FFFF_FFFF_8001, 64'h0000_0000_0000_8001, 64'hFFFF_FFFF_8001_00FF,
                                64'h0000_0000_8001_00FF, 64'h0000_0000_8001_00FF, 64'h0000_0000_0000_0000};
    xact(1'b1, 64'h20, 64'h1234_5678_9ABC_DEFF, F_LB, rd, er, lat);
    xact(1'b1, 64'h22, 64'hFFFF_FFFF_FFFF_8001, F_LH, rd, er, lat);
    for (int i = 0; i < 9; i++) begin
      xact(1'b0, t_addr[i], 64'd0, t_f3[i], rd, er, lat);
      vectors++; if (rd !== t_exp[i]) begin miscompares++; $display("FAIL ext_rdata[%0d] got %h exp %h", i, rd, t_exp[i]); end
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL ext_err[%0d] got %b exp 0", i, er); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd; logic er; int lat;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_funct3 = F_LD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL bp_latency got %0d exp %0d", lat, LAT); end
    // A competing store while the response is stalled must be ignored.
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 64'd0; req_funct3 = F_LD;
    for (int c = 0; c < 5; c++) begin
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d] got %b exp 1", c, rsp_valid); end
      vectors++; if (rsp_rdata !== DW) begin miscompares++; $display("FAIL bp_rdata[%0d] got %h exp %h", c, rsp_rdata, DW); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready[%0d] got %b exp 0", c, req_ready); end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_after_valid got %b exp 0", rsp_valid); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_after_ready got %b exp 1", req_ready); end
    xact(1'b0, 64'h10, 64'd0, F_LD, rd, er, lat);
    vectors++; if (rd !== DW) begin miscompares++; $display("FAIL bp_ignored_store got %h exp %h", rd, DW); end
  endtask

  task automatic test_wrap();
    logic [63:0] rd; logic er; int lat;
    logic [63:0] t_addr [4] = '{64'hFE, 64'hFF, 64'h00, 64'h01};
    logic [7:0]  t_byte [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    xact(1'b1, 64'hFE, 64'h0000_0000_AABB_CCDD, F_LW, rd, er, lat);
    vectors++; if (er !== mis) begin miscompares++; $display("FAIL wrap_sw_err got %b exp %b", er, mis); end
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, t_addr[i], 64'd0, F_LBU, rd, er, lat);
      vectors++; if (rd !== (mis ? 64'd0 : 64'(t_byte[i]))) begin
        miscompares++; $display("FAIL wrap_byte[%0d] got %h exp %h", i, rd, mis ? 64'd0 : 64'(t_byte[i]));
      end
    end
    xact(1'b0, 64'hFE, 64'd0, F_LW, rd, er, lat);
    vectors++; if (rd !== (mis ? 64'd0 : 64'hFFFF_FFFF_AABB_CCDD)) begin
      miscompares++; $display("FAIL wrap_lw got %h exp %h", rd, mis ? 64'd0 : 64'hFFFF_FFFF_AABB_CCDD);
    end
    vectors++; if (er !== mis) begin miscompares++; $display("FAIL wrap_lw_err got %b exp %b", er, mis); end
    xact(1'b0, 64'hFF, 64'd0, F_LH, rd, er, lat);
    vectors++; if (rd !== (mis ? 64'd0 : 64'hFFFF_FFFF_FFFF_BBCC)) begin
      miscompares++; $display("FAIL wrap_lh got %h exp %h", rd, mis ? 64'd0 : 64'hFFFF_FFFF_FFFF_BBCC);
    end
  endtask

  task automatic test_store_err();
    logic [63:0] rd; logic er; int lat;
    xact(1'b1, 64'h50, 64'h5A, F_LB, rd, er, lat);
    xact(1'b1, 64'h50, 64'h77, 3'b100, rd, er, lat);
    vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL sbu_err got %b exp 1", er); end
    vectors++; if (rd !== 64'd0) begin miscompares++; $display("FAIL sbu_rdata got %h exp 0", rd); end
    xact(1'b0, 64'h50, 64'd0, F_LBU, rd, er, lat);
    vectors++; if (rd !== 64'h5A) begin miscompares++; $display("FAIL sbu_unchanged got %h exp 5a", rd); end
    xact(1'b1, 64'h31, 64'h1234, F_LH, rd, er, lat);
    vectors++; if (er !== mis) begin miscompares++; $display("FAIL mis_sh_err got %b exp %b", er, mis); end
    xact(1'b0, 64'h31, 64'd0, F_LBU, rd, er, lat);
    vectors++; if (rd !== (mis ? 64'd0 : 64'h34)) begin
      miscompares++; $display("FAIL mis_byte got %h exp %h", rd, mis ? 64'd0 : 64'h34);
    end
    xact(1'b0, 64'h31, 64'd0, F_LHU, rd, er, lat);
    vectors++; if (rd !== (mis ? 64'd0 : 64'h1234)) begin
      miscompares++; $display("FAIL mis_lhu got %h exp %h", rd, mis ? 64'd0 : 64'h1234);
    end
    vectors++; if (er !== mis) begin miscompares++; $display("FAIL mis_lhu_err got %b exp %b", er, mis); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic er; int lat;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_funct3 = F_LD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    vectors++; if (rsp_rdata !== DW) begin miscompares++; $display("FAIL resp_pre_rdata got %h exp %h", rsp_rdata, DW); end
    reset = 1'b0; #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL resp_rst_valid got %b exp 0", rsp_valid); end
    vectors++; if (rsp_rdata !== 64'd0) begin miscompares++; $display("FAIL resp_rst_rdata got %h exp 0", rsp_rdata); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL resp_rst_err got %b exp 0", rsp_err); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL resp_rst_ready got %b exp 1", req_ready); end
    #1 reset = 1'b1;
    @(posedge clk); #1;

    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h40; req_wdata = 64'hDEAD_BEEF_0BAD_F00D; req_funct3 = F_LD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b0; #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL busy_rst_valid got %b exp 0", rsp_valid); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL busy_rst_ready got %b exp 1", req_ready); end
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL busy_rst_no_rsp got %b exp 0", rsp_valid); end
    xact(1'b0, 64'h40, 64'd0, F_LD, rd, er, lat);
    vectors++; if (rd !== 64'd0) begin miscompares++; $display("FAIL busy_rst_ld got %h exp 0", rd); end
    xact(1'b0, 64'h10, 64'd0, F_LD, rd, er, lat);
    vectors++; if (rd !== 64'd0) begin miscompares++; $display("FAIL busy_rst_clear got %h exp 0", rd); end
  endtask

  initial begin
`ifdef DMEM_MISALIGN_CHECK_EN
    mis = 1'b1;
`else
    mis = 1'b0;
`endif
    test_reset();
    test_dword();
    test_sign_ext();
    test_backpressure();
    test_wrap();
    test_store_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
